uart_frame_parser: RTL

Framing stage between the UART byte receiver and the 16-deep, 32-bit block RAM. It takes the receiver's validated byte stream and hunts for a sync byte. It parses a length-prefixed, checksummed frame, packs payload bytes big-endian into 32-bit words and issues one RAM write per completed word. It reports frame completion or a coded error so downstream control knows whether the RAM contents are a whole, correct frame.

---
 rtl/uart_frame_pkg.sv | 18 +
 rtl/uart_word_packer.sv | 34 +++
 rtl/uart_frame_parser.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared types and constants for the UART frame parser
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GET_LEN = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_GET_CHK = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_word_packer.sv
// rtl/uart_word_packer.sv - big-endian byte-to-word shift register with word-complete strobe
module uart_word_packer
  import uart_frame_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_next,
  output logic        o_word_done
);

  // Only the three older bytes need storage; the fourth arrives with the strobe.
  logic [23:0] word_q;
  logic [1:0]  idx_q;

  assign o_word_next = {word_q, i_byte};
  assign o_word_done = i_shift && (idx_q == 2'd3);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (i_clear) begin
      word_q <= '0;
      idx_q  <= '0;
    end else if (i_shift) begin
      word_q <= o_word_next[23:0];
      idx_q  <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - sync hunt, length/checksum framing and RAM word writes
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int         ADDR_W      = 4,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYC = 65536
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_data,
  input  logic              i_data_valid,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_frame_done,
  output logic              o_frame_err,
  output logic [1:0]        o_err_code,
  output logic [ADDR_W:0]   o_word_count,
  output logic              o_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int TW    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_t          state_q, state_d;
  logic [ADDR_W:0] len_q;
  logic [7:0]      chk_q;
  logic [TW-1:0]   tmo_q;

  logic        pk_shift;
  logic        pk_done;
  logic [31:0] pk_word;

  logic       sync_ev, len_ev, done_ev, err_ev, tmo_hit;
  logic [1:0] err_code_d;

  assign pk_shift = i_data_valid && (state_q == ST_PAYLOAD);
  // A byte arriving on the expiry cycle keeps the frame alive.
  assign tmo_hit  = (state_q != ST_IDLE) && !i_data_valid &&
                    (tmo_q == TW'(TIMEOUT_CYC - 1));

  uart_word_packer u_packer (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (sync_ev),
    .i_shift     (pk_shift),
    .i_byte      (i_data),
    .o_word_next (pk_word),
    .o_word_done (pk_done)
  );

  always_comb begin
    state_d    = state_q;
    sync_ev    = 1'b0;
    len_ev     = 1'b0;
    done_ev    = 1'b0;
    err_ev     = 1'b0;
    err_code_d = ERR_NONE;
    case (state_q)
      ST_IDLE: begin
        if (i_data_valid && (i_data == SYNC_BYTE)) begin
          sync_ev = 1'b1;
          state_d = ST_GET_LEN;
        end
      end
      ST_GET_LEN: begin
        if (i_data_valid) begin
          if ((i_data == 8'd0) || ({24'd0, i_data} > 32'(DEPTH))) begin
            err_ev     = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = ST_IDLE;
          end else begin
            len_ev  = 1'b1;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (pk_done && ((o_word_count + (ADDR_W+1)'(1)) == len_q)) begin
          state_d = ST_GET_CHK;
        end
      end
      ST_GET_CHK: begin
        if (i_data_valid) begin
          state_d = ST_IDLE;
          if (i_data == chk_q) begin
            done_ev = 1'b1;
          end else begin
            err_ev     = 1'b1;
            err_code_d = ERR_CHK;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo_hit) begin
      state_d    = ST_IDLE;
      err_ev     = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      chk_q        <= '0;
      tmo_q        <= '0;
      o_wr_en      <= 1'b0;
      o_wr_addr    <= '0;
      o_wr_data    <= '0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
      o_err_code   <= ERR_NONE;
      o_word_count <= '0;
      o_busy       <= 1'b0;
    end else begin
      state_q      <= state_d;
      o_busy       <= (state_d != ST_IDLE);
      o_wr_en      <= 1'b0;
      o_frame_done <= done_ev;
      o_frame_err  <= err_ev;

      if (sync_ev) begin
        o_word_count <= '0;
        o_err_code   <= ERR_NONE;
        chk_q        <= '0;
      end
      if (err_ev) begin
        o_err_code <= err_code_d;
      end
      if (len_ev) begin
        len_q <= i_data[ADDR_W:0];
        chk_q <= i_data;
      end
      if (pk_shift) begin
        chk_q <= chk_q ^ i_data;
      end
      if (pk_shift && pk_done) begin
        o_wr_en      <= 1'b1;
        o_wr_addr    <= o_word_count[ADDR_W-1:0];
        o_wr_data    <= pk_word;
        o_word_count <= o_word_count + (ADDR_W+1)'(1);
      end

      if (i_data_valid || (state_q == ST_IDLE) || tmo_hit) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end

endmodule
